// File: rtl/fc_argmax.sv
// Streaming argmax over one frame of NUM_CLASSES signed scores, with IDLE/RUN/DONE sequencing.
// Define FC_ARGMAX_MARGIN_EN to add the second-best tracker and the top-1/top-2 margin output.
module fc_argmax #(
    parameter int DATA_SIZE   = 16,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        score_valid,
    input  logic signed [DATA_SIZE-1:0] score_data,
    output logic                        score_ready,
    output logic                        busy,
    output logic                        fc_2_finish,
    output logic                        ans_valid,
    output logic [IDX_W-1:0]            ans,
    output logic signed [DATA_SIZE-1:0] max_score
`ifdef FC_ARGMAX_MARGIN_EN
    ,
    output logic [DATA_SIZE:0]          margin
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                      state_q;
    logic [IDX_W-1:0]            cnt_q;
    logic                        ready_q;
    logic                        busy_q;
    logic                        finish_q;
    logic                        ans_valid_q;
    logic [IDX_W-1:0]            ans_q;
    logic signed [DATA_SIZE-1:0] max_score_q;

    logic signed [DATA_SIZE-1:0] max_q, max_d;
    logic [IDX_W-1:0]            idx_q, idx_d;

    logic xfer;
    logic last_xfer;

`ifdef FC_ARGMAX_MARGIN_EN
    localparam logic signed [DATA_SIZE-1:0] MOST_NEG = {1'b1, {(DATA_SIZE-1){1'b0}}};

    logic signed [DATA_SIZE-1:0] sec_q, sec_d;
    logic [DATA_SIZE:0]          margin_q;

    // One extra bit keeps max - second non-negative even for full-range scores.
    function automatic logic [DATA_SIZE:0] top_gap(input logic signed [DATA_SIZE-1:0] a,
                                                   input logic signed [DATA_SIZE-1:0] b);
        logic signed [DATA_SIZE:0] d;
        d = {a[DATA_SIZE-1], a} - {b[DATA_SIZE-1], b};
        return d;
    endfunction
`endif

    assign xfer      = ready_q & score_valid;
    assign last_xfer = xfer && (cnt_q == IDX_W'(NUM_CLASSES - 1));

    // Strict greater-than keeps the earliest index on ties.
    always_comb begin
        max_d = max_q;
        idx_d = idx_q;
`ifdef FC_ARGMAX_MARGIN_EN
        sec_d = sec_q;
`endif
        if (cnt_q == '0) begin
            max_d = score_data;
            idx_d = '0;
`ifdef FC_ARGMAX_MARGIN_EN
            sec_d = MOST_NEG;
`endif
        end else if (score_data > max_q) begin
`ifdef FC_ARGMAX_MARGIN_EN
            sec_d = max_q;
`endif
            max_d = score_data;
            idx_d = cnt_q;
        end
`ifdef FC_ARGMAX_MARGIN_EN
        else if (score_data > sec_q) begin
            sec_d = score_data;
        end
`endif
    end

    // Running trackers are pure datapath; the first transfer of every frame reloads them.
    always_ff @(posedge clk) begin
        if (xfer) begin
            max_q <= max_d;
            idx_q <= idx_d;
`ifdef FC_ARGMAX_MARGIN_EN
            sec_q <= sec_d;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            finish_q    <= 1'b0;
            ans_valid_q <= 1'b0;
            ans_q       <= '0;
            max_score_q <= '0;
`ifdef FC_ARGMAX_MARGIN_EN
            margin_q    <= '0;
`endif
        end else begin
            finish_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q     <= S_RUN;
                        cnt_q       <= '0;
                        ready_q     <= 1'b1;
                        busy_q      <= 1'b1;
                        ans_valid_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (xfer) begin
                        cnt_q <= cnt_q + IDX_W'(1);
                    end
                    if (last_xfer) begin
                        state_q     <= S_DONE;
                        ready_q     <= 1'b0;
                        busy_q      <= 1'b0;
                        finish_q    <= 1'b1;
                        ans_valid_q <= 1'b1;
                        ans_q       <= idx_d;
                        max_score_q <= max_d;
`ifdef FC_ARGMAX_MARGIN_EN
                        margin_q    <= top_gap(max_d, sec_d);
`endif
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign score_ready = ready_q;
    assign busy        = busy_q;
    assign fc_2_finish = finish_q;
    assign ans_valid   = ans_valid_q;
    assign ans         = ans_q;
    assign max_score   = max_score_q;
`ifdef FC_ARGMAX_MARGIN_EN
    assign margin      = margin_q;
`endif

endmodule

// File: tb/tb_fc_argmax.sv
// Directed bench for fc_argmax: table of frames plus reset and back-to-back sequences.
module tb_fc_argmax;

    localparam int DW = 16;
    localparam int NC = 10;
    localparam int IW = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 score_valid;
    logic signed [DW-1:0] score_data;
    logic                 score_ready;
    logic                 busy;
    logic                 fc_2_finish;
    logic                 ans_valid;
    logic [IW-1:0]        ans;
    logic signed [DW-1:0] max_score;
`ifdef FC_ARGMAX_MARGIN_EN
    logic [DW:0]          margin;
`endif

    fc_argmax #(.DATA_SIZE(DW), .NUM_CLASSES(NC)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .score_valid(score_valid),
        .score_data (score_data),
        .score_ready(score_ready),
        .busy       (busy),
        .fc_2_finish(fc_2_finish),
        .ans_valid  (ans_valid),
        .ans        (ans),
        .max_score  (max_score)
`ifdef FC_ARGMAX_MARGIN_EN
        ,
        .margin     (margin)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NC-1:0][DW-1:0] s;
        logic [NC-1:0]         stall;     // one idle cycle before score i
        int                    start_at;  // index at which a stray start is driven, -1 none
        int                    exp_ans;
        int                    exp_max;
        int                    exp_margin;
        int                    exp_lat;
    } vec_t;

    vec_t vecs[5];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int fin_pulses = 0;
    int fin_cyc = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (fc_2_finish) begin
            fin_pulses = fin_pulses + 1;
            fin_cyc    = cyc;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [NC-1:0][DW-1:0] pack10(input int a[10]);
        logic [NC-1:0][DW-1:0] r;
        for (int i = 0; i < NC; i++) r[i] = a[i][DW-1:0];
        return r;
    endfunction

    task automatic run_frame(input vec_t v, input string tag, input int hold, input bit immediate);
        int p0;
        int t0;
        p0 = fin_pulses;
        t0 = 0;
        if (!immediate) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_ready_run"}, score_ready, 1);
        check({tag, "_busy_run"}, busy, 1);
        for (int i = 0; i < NC; i++) begin
            if (v.stall[i]) begin
                score_valid = 1'b0;
                score_data  = DW'($urandom);
                @(negedge clk);
            end
            score_valid = 1'b1;
            score_data  = v.s[i];
            if (i == 0) t0 = cyc;
            if (i == v.start_at) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int k = 0; k < 20 && !ans_valid; k++) @(negedge clk);
        if (!ans_valid) check({tag, "_finish_timeout"}, 0, 1);
        check({tag, "_latency"}, fin_cyc - t0, v.exp_lat);
        check({tag, "_ans"}, ans, v.exp_ans);
        check({tag, "_max"}, max_score, v.exp_max);
`ifdef FC_ARGMAX_MARGIN_EN
        check({tag, "_margin"}, margin, v.exp_margin);
`endif
        check({tag, "_ready_done"}, score_ready, 0);
        check({tag, "_busy_done"}, busy, 0);
        if (hold > 0) begin
            score_valid = 1'b1;
            score_data  = 16'sh7fff;
            repeat (hold) @(negedge clk);
            score_valid = 1'b0;
            check({tag, "_pulses"}, fin_pulses - p0, 1);
            check({tag, "_ans_hold"}, ans, v.exp_ans);
            check({tag, "_valid_hold"}, ans_valid, 1);
        end
    endtask

    initial begin
        int a[10];
        int p0;

        a = '{-5, 3, 12, 7, -100, 40, 0, 39, 1, 2};
        vecs[0] = '{s: pack10(a), stall: '0, start_at: -1,
                    exp_ans: 5, exp_max: 40, exp_margin: 1, exp_lat: 10};
        a = '{-32768, -32768, -32768, 7, -32768, -32768, -32768, -32768, 7, -32768};
        vecs[1] = '{s: pack10(a), stall: '0, start_at: -1,
                    exp_ans: 3, exp_max: 7, exp_margin: 0, exp_lat: 10};
        a = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2] = '{s: pack10(a), stall: '0, start_at: 9,
                    exp_ans: 0, exp_max: 0, exp_margin: 0, exp_lat: 10};
        a = '{-5, 3, 12, 7, -100, 40, 0, 39, 1, 2};
        vecs[3] = '{s: pack10(a), stall: 10'b00_1010_0100, start_at: 5,
                    exp_ans: 5, exp_max: 40, exp_margin: 1, exp_lat: 13};
        a = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, 32767};
        vecs[4] = '{s: pack10(a), stall: '0, start_at: -1,
                    exp_ans: 9, exp_max: 32767, exp_margin: 65535, exp_lat: 10};

        rst         = 1'b1;
        start       = 1'b0;
        score_valid = 1'b1;
        score_data  = 16'sh1234;
        repeat (3) @(negedge clk);
        check("rst_ready", score_ready, 0);
        check("rst_valid", ans_valid, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_ready", score_ready, 0);
        check("idle_busy", busy, 0);
        check("idle_finish_pulses", fin_pulses, 0);
        check("idle_ans_valid", ans_valid, 0);
        check("idle_ans", ans, 0);
        check("idle_max", max_score, 0);
`ifdef FC_ARGMAX_MARGIN_EN
        check("idle_margin", margin, 0);
`endif
        score_valid = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i], $sformatf("vec%0d", i), 3, 1'b0);
        end

        // Abort a frame after its fourth transfer.
        p0 = fin_pulses;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            score_valid = 1'b1;
            score_data  = vecs[0].s[i];
            @(negedge clk);
        end
        score_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_ready", score_ready, 0);
        check("abort_ans_valid", ans_valid, 0);
        check("abort_ans", ans, 0);
        check("abort_max", max_score, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_no_pulse", fin_pulses - p0, 0);

        // Back-to-back: second start in the cycle right after fc_2_finish.
        p0 = fin_pulses;
        run_frame(vecs[4], "b2b_a", 0, 1'b0);
        run_frame(vecs[1], "b2b_b", 2, 1'b1);
        check("b2b_pulses", fin_pulses - p0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fc_argmax.md
# fc_argmax

Streaming classifier output stage for the LeNet pipeline: accepts the final fully-connected layer's class scores one per cycle over a valid/ready handshake and reports the index of the largest signed score. It generalises the fixed 10-class, 4-bit answer of the current top level to any class count and score width. It adds explicit start/busy/finish sequencing, deterministic tie-breaking and an optional top-1/top-2 confidence margin. It sits between the fc_2 output and the top-level `ans`/`fc_2_finish` ports.

## Interface
- `DATA_SIZE`, 16, width of each signed two's-complement score.
- `NUM_CLASSES`, 10, number of scores per frame; legal range 2..256.
- `IDX_W`, `$clog2(NUM_CLASSES)`, width of the class index (4 for 10 classes).

- `clk`  input  1  single clock, rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  one-cycle pulse that opens a new frame; honoured only in IDLE or DONE.
- `score_valid`  input  1  `score_data` is valid this cycle.
- `score_data`  input  DATA_SIZE  signed score. Scores arrive in class order 0..NUM_CLASSES-1.
- `score_ready`  output  1  block accepts a score this cycle; high only in RUN.
- `busy`  output  1  high in RUN.
- `fc_2_finish`  output  1  one-cycle pulse when the result is updated.
- `ans_valid`  output  1  level; high in DONE until the next `start` or `rst`.
- `ans`  output  IDX_W  index of the maximum score.
- `max_score`  output  DATA_SIZE  value of the maximum score.
- `margin`  output  DATA_SIZE+1  unsigned top-1 minus top-2 difference; present only with `FC_ARGMAX_MARGIN_EN`.

## Operation
- State machine with three states: IDLE, RUN and DONE. Reset enters IDLE.
- IDLE or DONE with `start`=1:
  - go to RUN;
  - clear the count to 0;
  - clear `ans_valid`;
  - `ans`/`max_score` keep their old values until the frame completes.
- RUN:
  - a transfer occurs when `score_valid` and `score_ready` are both high;
  - each transfer increments the count;
  - cycles without `score_valid` are stalls with no state change.
- First transfer (count 0): the running max is loaded with the score and the running index with 0. The second-best register is loaded with the most negative value, -2^(DATA_SIZE-1).
- Later transfers:
  - if score > max (strict signed comparison): second ← max, max ← score, index ← count;
  - else if score > second: second ← score;
  - else: no change.
- Ties resolve to the lowest index.
- When the transfer with count == NUM_CLASSES-1 occurs:
  - go to DONE;
  - register `ans`, `max_score` (and `margin`) from the updated values;
  - pulse `fc_2_finish`.
- DONE: results hold and `score_ready`=0. `score_valid` is ignored.
- `start` in RUN is ignored. The frame continues.
- `start` on the same cycle as the last transfer is ignored. The block enters DONE.
- `margin` = max − second, computed in DATA_SIZE+1 bits so that full-range scores cannot overflow. Its range is 0..2^DATA_SIZE−1.
- All-equal scores give `ans`=0 and `margin`=0.

## Timing
- Reset values of all outputs are 0: `score_ready`, `busy`, `fc_2_finish`, `ans_valid`, `ans`, `max_score` and `margin`.
- `start` is sampled at edge N. `score_ready` and `busy` are high from cycle N+1.
- With no stalls, NUM_CLASSES transfers take exactly NUM_CLASSES cycles.
- The last transfer is at edge M. At edge M the block registers `fc_2_finish`=1 and `ans_valid`=1 and updates `ans`, so all three are visible in cycle M+1. `score_ready` and `busy` are 0 in cycle M+1.
- `fc_2_finish` is high for exactly one cycle per frame.
- The earliest back-to-back `start` is in cycle M+1, giving a minimum frame period of NUM_CLASSES+1 cycles.
- Asserting `rst` mid-frame immediately forces IDLE and zeroes all outputs, asynchronously. No `fc_2_finish` is produced for the aborted frame.
- `score_ready` is a registered state decode. It does not depend combinationally on `score_valid`.

## Configuration
- Macro `FC_ARGMAX_MARGIN_EN`.
- Defined: the second-best register, its compare logic and the `margin` port exist.
- Undefined: the `margin` port, the second-best register and its compare logic are all absent; everything else is unchanged.

## Test plan
- Reset and idle:
  - hold `rst`, then release it with `score_valid`=1 and no `start`;
  - required: `score_ready`=0, no `fc_2_finish`, all outputs 0.
- Basic frame, DATA_SIZE=16, NUM_CLASSES=10:
  - scores −5, 3, 12, 7, −100, 40, 0, 39, 1, 2, one per cycle with no stalls;
  - required: `fc_2_finish` exactly 10 cycles after the first transfer, `ans`=5, `max_score`=40, `margin`=1.
- Ties and signed compare:
  - scores all −32768 except index 3 = 7 and index 8 = 7;
  - required: `ans`=3, `margin`=0.
  - second frame: all scores 0;
  - required: `ans`=0.
- Stalls and an ignored start:
  - the basic frame with `score_valid` dropped for 3 random cycles, and a `start` pulse mid-frame;
  - required: same result as the basic frame, `fc_2_finish` 3 cycles later, a single pulse.
- Margin extremes:
  - scores 32767 at index 9 and −32768 elsewhere;
  - required: `ans`=9, `margin`=65535.
  - with the macro undefined, the bench compiles and checks `ans`=9 only.
- Reset mid-frame, then back-to-back frames:
  - assert `rst` after the 4th transfer, then run two frames with `start` in the cycle immediately after `fc_2_finish`;
  - required: no pulse for the aborted frame and a correct `ans` for each of the two frames.
